// File: rtl/dpram_core.sv
// Plain dual-port storage: one write port, two registered read ports, read-first.
// The array has no reset so synthesis can map it onto block RAM.
module dpram_core #(
  parameter int aw = 8,
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic [aw-1:0] raddr_a,
  output logic [dw-1:0] rdata_a,
  input  logic [aw-1:0] raddr_b,
  output logic [dw-1:0] rdata_b
);

  logic [dw-1:0] mem [0:(1<<aw)-1];
  logic [dw-1:0] rdata_a_q, rdata_b_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_a_q <= mem[raddr_a];
    rdata_b_q <= mem[raddr_b];
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/dpram_acc.sv
// Dual-port RAM with read-modify-write accumulate on port A, plain read port B
// and a hardware clear sweep that streams zero-writes through the port A pipeline.
module dpram_acc #(
  parameter int aw  = 8,
  parameter int dw  = 16,
  parameter int sat = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [aw-1:0] addra,
  input  logic [dw-1:0] dina,
  input  logic          wena,
  input  logic          acca,
  output logic [dw-1:0] douta,
  input  logic [aw-1:0] addrb,
  output logic [dw-1:0] doutb,
  input  logic          clr,
  output logic          busy
);

  localparam logic st_idle  = 1'b0;
  localparam logic st_sweep = 1'b1;

  logic          state_q, state_d;
  logic [aw-1:0] cnt_q, cnt_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s1_wr_q, s1_wr_d;
  logic [aw-1:0] s1_addr_q, s1_addr_d;
  logic [dw-1:0] s1_data_q, s1_data_d;
  logic          hit_q, hit_d;
  logic [dw-1:0] fwd_q, fwd_d;
  logic          rd_vld_q, rd_vld_d;

  logic          we;
  logic [aw-1:0] waddr;
  logic [dw-1:0] wdata;
  logic [dw-1:0] ram_a, ram_b;
  logic [dw-1:0] old_a;
  logic [dw:0]   sum;
  logic [dw-1:0] acc_res;

  dpram_core #(.aw(aw), .dw(dw)) u_core (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (addra),
    .rdata_a (ram_a),
    .raddr_b (addrb),
    .rdata_b (ram_b)
  );

  // Commit stage: the op captured last cycle writes now. The RAM read for the
  // same op missed only the write that shared its read edge, which hit_q covers.
  always_comb begin
    busy    = (state_q == st_sweep);
    old_a   = hit_q ? fwd_q : ram_a;
    sum     = {1'b0, old_a} + {1'b0, s1_data_q};
    acc_res = sum[dw-1:0];
    if (sat != 0 && sum[dw]) acc_res = '1;
    we      = s1_vld_q & ~rst;
    waddr   = s1_addr_q;
    wdata   = s1_wr_q ? s1_data_q : acc_res;
    douta   = rd_vld_q ? old_a : '0;
    doutb   = rd_vld_q ? ram_b : '0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s1_vld_d  = wena | acca;
    s1_wr_d   = wena;
    s1_addr_d = addra;
    s1_data_d = dina;
    case (state_q)
      st_idle: begin
        if (clr) begin
          state_d = st_sweep;
          cnt_d   = '0;
        end
      end
      default: begin
        if (clr) cnt_d = '0;
        else if (cnt_q == '1) begin
          state_d = st_idle;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
    endcase
    // While sweeping, user strobes are dropped and a zero-write is issued instead.
    if (busy) begin
      s1_vld_d  = 1'b1;
      s1_wr_d   = 1'b1;
      s1_addr_d = cnt_q;
      s1_data_d = '0;
    end
    hit_d    = we && (waddr == addra);
    fwd_d    = wdata;
    rd_vld_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= st_idle;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_wr_q   <= 1'b0;
      s1_addr_q <= '0;
      s1_data_q <= '0;
      hit_q     <= 1'b0;
      fwd_q     <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_wr_q   <= s1_wr_d;
      s1_addr_q <= s1_addr_d;
      s1_data_q <= s1_data_d;
      hit_q     <= hit_d;
      fwd_q     <= fwd_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

endmodule

// File: tb/tb_dpram_acc.sv
// Directed bench for dpram_acc: a wrapping and a saturating instance share stimulus.
module tb_dpram_acc;

  localparam int aw = 4;
  localparam int dw = 16;

  logic          clk = 1'b0;
  logic          rst, wena, acca, clr;
  logic [aw-1:0] addra, addrb;
  logic [dw-1:0] dina;
  logic [dw-1:0] douta0, doutb0, douta1, doutb1;
  logic          busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dpram_acc #(.aw(aw), .dw(dw), .sat(0)) u_wrap (
    .clk(clk), .rst(rst), .addra(addra), .dina(dina), .wena(wena), .acca(acca),
    .douta(douta0), .addrb(addrb), .doutb(doutb0), .clr(clr), .busy(busy0)
  );

  dpram_acc #(.aw(aw), .dw(dw), .sat(1)) u_sat (
    .clk(clk), .rst(rst), .addra(addra), .dina(dina), .wena(wena), .acca(acca),
    .douta(douta1), .addrb(addrb), .doutb(doutb1), .clr(clr), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int cnt;

  initial begin
    rst = 1'b1; wena = 1'b0; acca = 1'b0; clr = 1'b0;
    addra = '0; addrb = '0; dina = '0;
    tick; tick;
    chk("rst_douta", douta0, 0);
    chk("rst_doutb", doutb0, 0);
    chk("rst_busy", busy0, 0);
    rst = 1'b0;
    tick;

    // full sweep with a write attempted mid-sweep
    clr = 1'b1; tick; clr = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 100) begin
      if (cnt == 5) begin wena = 1'b1; addra = 4'd2; dina = 16'hAAAA; end
      else wena = 1'b0;
      cnt++;
      tick;
    end
    wena = 1'b0;
    chk("sweep_len", cnt, 16);
    tick;
    for (int a = 0; a < 16; a++) begin
      addra = a[aw-1:0]; addrb = a[aw-1:0];
      tick;
      chk($sformatf("swept_a%0d", a), douta0, 0);
      chk($sformatf("swept_b%0d", a), doutb0, 0);
    end

    // restart mid-sweep
    clr = 1'b1; tick; clr = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    clr = 1'b1; tick; clr = 1'b0;
    cnt = 0;
    while (busy0 && cnt < 100) begin cnt++; tick; end
    chk("restart_len", cnt, 16);
    tick;

    // plain write, A readback with forwarding, B readback two cycles later
    addra = 4'd5; dina = 16'h1234; wena = 1'b1; addrb = 4'd0;
    tick;
    wena = 1'b0;
    tick;
    chk("wr_douta", douta0, 16'h1234);
    addrb = 4'd5;
    tick;
    chk("wr_doutb", doutb0, 16'h1234);

    // back-to-back accumulates
    addra = 4'd7; dina = 16'd1; acca = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk($sformatf("acc_stream%0d", i), douta0, i);
    end
    acca = 1'b0;
    tick;
    chk("acc_final", douta0, 10);

    // wrap vs saturate
    addra = 4'd9; dina = 16'hFFF0; wena = 1'b1;
    tick;
    wena = 1'b0; acca = 1'b1; dina = 16'h0020;
    tick;
    acca = 1'b0;
    chk("sat_old", douta1, 16'hFFF0);
    tick;
    chk("wrap_res", douta0, 16'h0010);
    chk("sat_res", douta1, 16'hFFFF);

    // write wins over accumulate
    addra = 4'd11; dina = 16'd4; wena = 1'b1;
    tick;
    dina = 16'd9; acca = 1'b1;
    tick;
    wena = 1'b0; acca = 1'b0;
    tick;
    chk("both_strobes", douta0, 9);

    // reset drops an in-flight accumulate
    addra = 4'd3; dina = 16'h0050; wena = 1'b1;
    tick;
    wena = 1'b0; acca = 1'b1; dina = 16'd5;
    tick;
    acca = 1'b0; rst = 1'b1;
    tick;
    chk("rstmid_douta", douta0, 0);
    chk("rstmid_doutb", doutb0, 0);
    chk("rstmid_busy", busy0, 0);
    rst = 1'b0; addrb = 4'd3;
    tick;
    chk("rst_drop_a", douta0, 16'h0050);
    chk("rst_drop_b", doutb0, 16'h0050);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
